closed_list_writer: RTL and testbench
=====================================

CLOSED_LIST_WRITER -- requirements
Module: closed_list_writer

Interface
REQ-001 Parameter DEPTH, default 400, closed-list entry count.
REQ-002 Parameter COORD_W, default 8, coordinate width.
REQ-003 Parameter IDX_W, default 9, index/count width; SHALL satisfy 2^IDX_W > DEPTH.
REQ-004 Clk  input  1  clock; all state changes on rising edge.
REQ-005 Reset  input  1  reset, asynchronous, active-high.
REQ-006 wr_valid  input  1  insert request.
REQ-007 wr_x  input  COORD_W  node x to append.
REQ-008 wr_y  input  COORD_W  node y to append.
REQ-009 wr_ready  output  1  insert accepted this cycle if wr_valid high.
REQ-010 wr_done  output  1  one-cycle pulse, entry committed.
REQ-011 wr_overflow  output  1  one-cycle pulse, insert attempted while full.
REQ-012 clear_req  input  1  level request to empty the list.
REQ-013 clear_busy  output  1  high while clearing.
REQ-014 count  output  IDX_W  number of valid entries.
REQ-015 full  output  1  count == DEPTH.
REQ-016 rd_index  input  IDX_W  search-side read address.
REQ-017 rd_x  output  COORD_W  registered x at rd_index.
REQ-018 rd_y  output  COORD_W  registered y at rd_index.

Function
REQ-019 Storage: two DEPTH x COORD_W arrays (x, y), entries 0..count-1 valid, appended in order.
REQ-020 FSM states IDLE, WRITE, CLEAR; Reset forces IDLE.
REQ-021 wr_ready = 1 only in IDLE, with full = 0, clear_req = 0 and Reset = 0.
REQ-022 IDLE, wr_valid & wr_ready at edge: latch wr_x/wr_y, go WRITE.
REQ-023 WRITE: mem[count] <= latched pair; count <= count+1; wr_done = 1 for that one cycle; next state IDLE.
REQ-024 Throughput: one insert per 2 cycles; new entry readable via rd port from the first edge after WRITE.
REQ-025 IDLE, wr_valid = 1 and full = 1: no write, count unchanged; wr_overflow pulses 1 cycle after each such sampled cycle.
REQ-026 IDLE, clear_req = 1: takes priority over wr_valid; go CLEAR, count <= 0, clear pointer <= 0.
REQ-027 CLEAR: each cycle writes all-ones sentinel to x and y at pointer and increments pointer; at pointer == DEPTH-1, writes and returns to IDLE; clear takes exactly DEPTH cycles.
REQ-028 clear_busy = 1 in every CLEAR cycle, else 0; wr_valid ignored during CLEAR (no overflow pulse).
REQ-029 clear_req asserted during WRITE: WRITE completes first; clear begins from the following IDLE if still high.
REQ-030 Read port: rd_x/rd_y <= mem[rd_index] every edge, 1-cycle latency, in all states.
REQ-031 rd_index >= DEPTH: rd_x/rd_y return all-ones.
REQ-032 Read and write to the same index in one cycle: read returns pre-write data.
REQ-033 count never exceeds DEPTH; no wrap-around on append.

Reset
REQ-034 Reset high: state IDLE, count 0, wr_done 0, wr_overflow 0, clear_busy 0, rd_x/rd_y 0, wr_ready 0.
REQ-035 Memory contents are not reset; undefined until written or cleared.
REQ-036 Reset during WRITE or CLEAR aborts the operation: count 0, pending entry discarded, memory partially cleared.

Verification
REQ-037 After reset, insert (3,5) then (7,9) -> wr_done twice, count 2; rd_index 0 -> (3,5), rd_index 1 -> (7,9) one cycle later.
REQ-038 wr_valid held high continuously -> wr_ready alternates 1/0; 10 inserts finish in 20 cycles, count 10.
REQ-039 Fill to 400 -> full 1, wr_ready 0; one more wr_valid cycle -> wr_overflow single pulse, count stays 400.
REQ-040 count 5, clear_req and wr_valid together in IDLE -> CLEAR taken, clear_busy high exactly 400 cycles, count 0, rd_index 2 -> (FF,FF).
REQ-041 Assert Reset mid-CLEAR (cycle 100) -> state IDLE, count 0, clear_busy 0 immediately; next insert lands at index 0.
REQ-042 rd_index 450 -> rd_x/rd_y = FF; write and read same index same cycle -> old value returned, new value next read.

Source files
------------

// File: rtl/closed_list_writer_if.sv
// Bus bundle for the closed-list writer: append port, clear control,
// occupancy status and the search-side read port.
interface closed_list_writer_if #(
    parameter int COORD_W = 8,
    parameter int IDX_W   = 9
);
    logic               wr_valid;
    logic [COORD_W-1:0] wr_x;
    logic [COORD_W-1:0] wr_y;
    logic               wr_ready;
    logic               wr_done;
    logic               wr_overflow;
    logic               clear_req;
    logic               clear_busy;
    logic [IDX_W-1:0]   count;
    logic               full;
    logic [IDX_W-1:0]   rd_index;
    logic [COORD_W-1:0] rd_x;
    logic [COORD_W-1:0] rd_y;

    // Requester side: issues inserts, clears and reads.
    modport master (
        output wr_valid, wr_x, wr_y, clear_req, rd_index,
        input  wr_ready, wr_done, wr_overflow, clear_busy, count, full, rd_x, rd_y
    );

    // Closed-list storage side.
    modport slave (
        input  wr_valid, wr_x, wr_y, clear_req, rd_index,
        output wr_ready, wr_done, wr_overflow, clear_busy, count, full, rd_x, rd_y
    );
endinterface

// File: rtl/closed_list_writer.sv
// Closed-list writer: append-only (x,y) store with a sentinel-filling clear
// sequence and a registered search-side read port.
module closed_list_writer #(
    parameter int DEPTH   = 400,
    parameter int COORD_W = 8,
    parameter int IDX_W   = 9
) (
    input logic                 Clk,
    input logic                 Reset,
    closed_list_writer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_CLEAR = 2'd2
    } state_t;

    localparam logic [IDX_W-1:0]   DEPTH_IDX = IDX_W'(DEPTH);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DEPTH - 1);
    localparam logic [IDX_W-1:0]   IDX_ONE   = IDX_W'(1);
    localparam logic [COORD_W-1:0] SENTINEL  = {COORD_W{1'b1}};

    // Storage is deliberately not reset; contents are defined only once
    // written by an append or by a clear pass.
    logic [COORD_W-1:0] r_mem_x [DEPTH];
    logic [COORD_W-1:0] r_mem_y [DEPTH];

    state_t             r_state;
    logic [IDX_W-1:0]   r_count;
    logic [IDX_W-1:0]   r_clr_ptr;
    logic [COORD_W-1:0] r_lat_x;
    logic [COORD_W-1:0] r_lat_y;
    logic               r_wr_done;
    logic               r_wr_overflow;
    logic               r_clear_busy;
    logic [COORD_W-1:0] r_rd_x;
    logic [COORD_W-1:0] r_rd_y;

    logic               w_full;
    logic               w_wr_ready;
    logic               w_we;
    logic [IDX_W-1:0]   w_waddr;
    logic [COORD_W-1:0] w_wdata_x;
    logic [COORD_W-1:0] w_wdata_y;

    // Occupancy and accept qualification; ready drops as soon as Reset rises.
    always_comb begin
        w_full     = (r_count == DEPTH_IDX);
        w_wr_ready = (r_state == ST_IDLE) && !w_full && !bus.clear_req && !Reset;
    end

    // Select the single write port source: latched pair in WRITE, sentinel in CLEAR.
    always_comb begin
        w_we      = 1'b0;
        w_waddr   = r_count;
        w_wdata_x = r_lat_x;
        w_wdata_y = r_lat_y;
        case (r_state)
            ST_WRITE: begin
                w_we      = 1'b1;
                w_waddr   = r_count;
                w_wdata_x = r_lat_x;
                w_wdata_y = r_lat_y;
            end
            ST_CLEAR: begin
                w_we      = 1'b1;
                w_waddr   = r_clr_ptr;
                w_wdata_x = SENTINEL;
                w_wdata_y = SENTINEL;
            end
            default: begin
                w_we = 1'b0;
            end
        endcase
    end

    // Control FSM with registered done/overflow/busy flags.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_clr_ptr     <= '0;
            r_lat_x       <= '0;
            r_lat_y       <= '0;
            r_wr_done     <= 1'b0;
            r_wr_overflow <= 1'b0;
            r_clear_busy  <= 1'b0;
        end else begin
            r_wr_done     <= 1'b0;
            r_wr_overflow <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear_req) begin
                        // Clear outranks any pending insert.
                        r_state      <= ST_CLEAR;
                        r_count      <= '0;
                        r_clr_ptr    <= '0;
                        r_clear_busy <= 1'b1;
                    end else if (bus.wr_valid && w_wr_ready) begin
                        r_lat_x   <= bus.wr_x;
                        r_lat_y   <= bus.wr_y;
                        r_state   <= ST_WRITE;
                        r_wr_done <= 1'b1;
                    end else if (bus.wr_valid && w_full) begin
                        r_wr_overflow <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    // Commit happens on this edge via the write port.
                    r_count <= r_count + IDX_ONE;
                    r_state <= ST_IDLE;
                end
                ST_CLEAR: begin
                    if (r_clr_ptr == LAST_IDX) begin
                        r_state      <= ST_IDLE;
                        r_clear_busy <= 1'b0;
                    end else begin
                        r_clr_ptr    <= r_clr_ptr + IDX_ONE;
                        r_clear_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_clear_busy <= 1'b0;
                end
            endcase
        end
    end

    // Memory write port (no reset on storage).
    always_ff @(posedge Clk) begin
        if (w_we) begin
            r_mem_x[w_waddr] <= w_wdata_x;
            r_mem_y[w_waddr] <= w_wdata_y;
        end
    end

    // Registered read port; same-edge write is not visible until the next read.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_rd_x <= '0;
            r_rd_y <= '0;
        end else if (bus.rd_index >= DEPTH_IDX) begin
            r_rd_x <= SENTINEL;
            r_rd_y <= SENTINEL;
        end else begin
            r_rd_x <= r_mem_x[bus.rd_index];
            r_rd_y <= r_mem_y[bus.rd_index];
        end
    end

    assign bus.wr_ready    = w_wr_ready;
    assign bus.wr_done     = r_wr_done;
    assign bus.wr_overflow = r_wr_overflow;
    assign bus.clear_busy  = r_clear_busy;
    assign bus.count       = r_count;
    assign bus.full        = w_full;
    assign bus.rd_x        = r_rd_x;
    assign bus.rd_y        = r_rd_y;

endmodule

// File: tb/tb_closed_list_writer.sv
// Directed testbench for closed_list_writer with hand-computed expectations.
module tb_closed_list_writer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_miss;

    closed_list_writer_if #(.COORD_W(8), .IDX_W(9)) bus ();

    closed_list_writer #(.DEPTH(400), .COORD_W(8), .IDX_W(9)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic do_insert(input logic [7:0] x, input logic [7:0] y);
        check_val("ins_ready", 32'(bus.wr_ready), 32'd1);
        bus.wr_valid = 1'b1;
        bus.wr_x     = x;
        bus.wr_y     = y;
        tick();
        check_val("ins_done", 32'(bus.wr_done), 32'd1);
        bus.wr_valid = 1'b0;
        tick();
        check_val("ins_done_clr", 32'(bus.wr_done), 32'd0);
    endtask

    task automatic do_clear(output int busy_cnt, output int ovf_cnt);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        check_val("clr_count0", 32'(bus.count), 32'd0);
        busy_cnt = 0;
        ovf_cnt  = 0;
        for (int c = 0; c < 1000 && bus.clear_busy; c++) begin
            busy_cnt++;
            if (bus.wr_overflow) ovf_cnt++;
            tick();
        end
        if (bus.wr_overflow) ovf_cnt++;
    endtask

    task automatic read_at(input logic [8:0] idx, input logic [7:0] ex, input logic [7:0] ey, input string tag);
        bus.rd_index = idx;
        tick();
        check_val({tag, "_x"}, 32'(bus.rd_x), 32'(ex));
        check_val({tag, "_y"}, 32'(bus.rd_y), 32'(ey));
    endtask

    initial begin
        int busy_cnt;
        int ovf_cnt;
        logic [7:0] vx;
        n_vec = 0;
        n_miss = 0;
        rst = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_x = 8'h00;
        bus.wr_y = 8'h00;
        bus.clear_req = 1'b0;
        bus.rd_index = 9'd0;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check_val("rst_ready", 32'(bus.wr_ready), 32'd0);
        check_val("rst_count", 32'(bus.count), 32'd0);
        check_val("rst_done", 32'(bus.wr_done), 32'd0);
        check_val("rst_ovf", 32'(bus.wr_overflow), 32'd0);
        check_val("rst_busy", 32'(bus.clear_busy), 32'd0);
        check_val("rst_rdx", 32'(bus.rd_x), 32'd0);
        check_val("rst_rdy", 32'(bus.rd_y), 32'd0);
        tick();
        check_val("rst_ready_hold", 32'(bus.wr_ready), 32'd0);
        rst = 1'b0;
        tick();
        check_val("post_rst_ready", 32'(bus.wr_ready), 32'd1);

        // Two inserts and readback
        do_insert(8'd3, 8'd5);
        check_val("cnt1", 32'(bus.count), 32'd1);
        do_insert(8'd7, 8'd9);
        check_val("cnt2", 32'(bus.count), 32'd2);
        read_at(9'd0, 8'd3, 8'd5, "rd0");
        read_at(9'd1, 8'd7, 8'd9, "rd1");

        // wr_valid held: ready alternates, 10 inserts in 20 cycles
        do_reset();
        bus.wr_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            vx = 8'(8'h10 + c / 2);
            bus.wr_x = vx;
            bus.wr_y = ~vx;
            check_val("alt_ready", 32'(bus.wr_ready), ((c % 2) == 0) ? 32'd1 : 32'd0);
            tick();
        end
        bus.wr_valid = 1'b0;
        check_val("cnt10", 32'(bus.count), 32'd10);
        read_at(9'd9, 8'h19, 8'hE6, "rd9");

        // Fill to capacity
        bus.wr_valid = 1'b1;
        for (int c = 0; c < 780; c++) begin
            vx = 8'(10 + c / 2);
            bus.wr_x = vx;
            bus.wr_y = ~vx;
            tick();
        end
        check_val("cnt400", 32'(bus.count), 32'd400);
        check_val("full1", 32'(bus.full), 32'd1);
        check_val("full_ready", 32'(bus.wr_ready), 32'd0);
        check_val("ovf_pre", 32'(bus.wr_overflow), 32'd0);
        tick();
        check_val("ovf_pulse", 32'(bus.wr_overflow), 32'd1);
        check_val("ovf_nodone", 32'(bus.wr_done), 32'd0);
        bus.wr_valid = 1'b0;
        tick();
        check_val("ovf_end", 32'(bus.wr_overflow), 32'd0);
        check_val("cnt_still400", 32'(bus.count), 32'd400);
        read_at(9'd200, 8'hC8, 8'h37, "rd200");
        read_at(9'd399, 8'h8F, 8'h70, "rd399");

        // Clear while full with wr_valid held: no overflow during clear
        bus.wr_valid = 1'b1;
        do_clear(busy_cnt, ovf_cnt);
        bus.wr_valid = 1'b0;
        check_val("fullclr_busy", 32'(busy_cnt), 32'd400);
        check_val("fullclr_noovf", 32'(ovf_cnt), 32'd0);
        check_val("fullclr_cnt", 32'(bus.count), 32'd0);
        read_at(9'd399, 8'hFF, 8'hFF, "rd399clr");

        // count 5, clear and insert requested together
        do_reset();
        for (int i = 0; i < 5; i++) do_insert(8'(i + 1), 8'(i + 8'h41));
        check_val("cnt5", 32'(bus.count), 32'd5);
        read_at(9'd2, 8'h03, 8'h43, "rd2pre");
        bus.wr_valid = 1'b1;
        bus.clear_req = 1'b1;
        #1;
        check_val("clrprio_ready", 32'(bus.wr_ready), 32'd0);
        do_clear(busy_cnt, ovf_cnt);
        bus.wr_valid = 1'b0;
        check_val("clr_busy400", 32'(busy_cnt), 32'd400);
        check_val("clr_cnt0", 32'(bus.count), 32'd0);
        check_val("clr_nodone", 32'(bus.wr_done), 32'd0);
        read_at(9'd2, 8'hFF, 8'hFF, "rd2clr");

        // Clear requested during WRITE, then Reset at clear cycle 100
        do_insert(8'h11, 8'h12);
        do_insert(8'h13, 8'h14);
        bus.wr_valid = 1'b1;
        bus.wr_x = 8'h15;
        bus.wr_y = 8'h16;
        tick();
        bus.wr_valid = 1'b0;
        bus.clear_req = 1'b1;
        tick();
        check_val("wrclr_cnt3", 32'(bus.count), 32'd3);
        check_val("wrclr_busy0", 32'(bus.clear_busy), 32'd0);
        tick();
        bus.clear_req = 1'b0;
        check_val("wrclr_busy1", 32'(bus.clear_busy), 32'd1);
        check_val("wrclr_cnt0", 32'(bus.count), 32'd0);
        for (int c = 0; c < 99; c++) tick();
        check_val("mid_busy", 32'(bus.clear_busy), 32'd1);
        rst = 1'b1;
        #1;
        check_val("abort_busy", 32'(bus.clear_busy), 32'd0);
        check_val("abort_cnt", 32'(bus.count), 32'd0);
        check_val("abort_ready", 32'(bus.wr_ready), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        do_insert(8'h55, 8'h66);
        read_at(9'd0, 8'h55, 8'h66, "rd0after");

        // Out-of-range read and same-index read/write collision
        read_at(9'd450, 8'hFF, 8'hFF, "rd450");
        bus.rd_index = 9'd1;
        bus.wr_valid = 1'b1;
        bus.wr_x = 8'h21;
        bus.wr_y = 8'h22;
        tick();
        bus.wr_valid = 1'b0;
        tick();
        check_val("coll_old_x", 32'(bus.rd_x), 32'h0FF);
        check_val("coll_old_y", 32'(bus.rd_y), 32'h0FF);
        tick();
        check_val("coll_new_x", 32'(bus.rd_x), 32'h021);
        check_val("coll_new_y", 32'(bus.rd_y), 32'h022);
        check_val("cnt_final", 32'(bus.count), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
